// File: rtl/sg_lock_ctrl.sv
// sg_lock_ctrl: holds the output sync generator in reset until the
// synchronized video reference shows a stable frame period for
// LOCK_FRAMES consecutive frames. It drops back to measuring on loss of
// lock and reports the frame period, the line count and a loss counter.

module sg_lock_ctrl #(
    parameter int CNT_W       = 24,
    parameter int TOL         = 16,
    parameter int LOCK_FRAMES = 4
) (
    input  logic             PCLK,
    input  logic             reset,
    input  logic             enable,
    input  logic             HSYNC_ref,
    input  logic             VSYNC_ref,
    output logic             sg_reset_n,
    output logic             locked,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] frame_period,
    output logic [10:0]      lines_per_frame,
    output logic [7:0]       loss_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_VERIFY  = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam logic [CNT_W:0] TOL_X    = (CNT_W+1)'(TOL);
    localparam logic [4:0]     LOCK_X   = 5'(LOCK_FRAMES);
    localparam logic [10:0]    LINE_MAX = 11'd2047;
    localparam logic [7:0]     LOSS_MAX = 8'hFF;

    // Registered state and datapath
    state_t           state_q,        state_d;
    logic             sg_reset_n_q,   sg_reset_n_d;
    logic             locked_q,       locked_d;
    logic             prev_vs_q,      prev_hs_q;
    logic [CNT_W-1:0] pctr_q,         pctr_d;
    logic [10:0]      line_q,         line_d;
    logic [CNT_W-1:0] ref_q,          ref_d;
    logic [3:0]       match_q,        match_d;
    logic             started_q,      started_d;  // first MEASURE edge seen
    logic             armed_q,        armed_d;    // an edge seen since IDLE
    logic [CNT_W-1:0] frame_period_q, frame_period_d;
    logic [10:0]      lines_q,        lines_d;
    logic [7:0]       loss_q,         loss_d;

    // Edge detect and period arithmetic
    logic             vs_edge, hs_edge;
    logic [CNT_W:0]   pctr_x, ref_x, diff, limit;
    logic             in_tol, timeout;
    logic [4:0]       match_inc;
    logic [CNT_W-1:0] pctr_step;
    logic [10:0]      line_step;
    logic             hold_idle;

    assign vs_edge = prev_vs_q & ~VSYNC_ref;
    assign hs_edge = prev_hs_q & ~HSYNC_ref;

    // One extra bit keeps |pctr-ref| and ref+TOL free of wrap-around.
    assign pctr_x  = {1'b0, pctr_q};
    assign ref_x   = {1'b0, ref_q};
    assign diff    = (pctr_x >= ref_x) ? (pctr_x - ref_x) : (ref_x - pctr_x);
    assign limit   = ref_x + TOL_X;
    assign in_tol  = (diff <= TOL_X);
    assign timeout = (pctr_x > limit);

    assign match_inc = {1'b0, match_q} + 5'd1;

    // Period counter restarts at 1 on an edge and sticks at all-ones.
    assign pctr_step = vs_edge      ? CNT_W'(1) :
                       (&pctr_q)    ? pctr_q    :
                                      pctr_q + CNT_W'(1);

    // A line edge coincident with the frame edge belongs to the new frame as 0.
    assign line_step = vs_edge                          ? 11'd0        :
                       (hs_edge && line_q != LINE_MAX)  ? line_q + 11'd1 :
                                                          line_q;

    assign hold_idle = !enable || (state_q == ST_IDLE);

    // Next-state, counter and report logic
    always_comb begin
        // NOTE: every signal driven here gets a default first so that no
        // branch can leave it unassigned and infer a latch.
        state_d        = state_q;
        pctr_d         = pctr_step;
        line_d         = line_step;
        ref_d          = ref_q;
        match_d        = match_q;
        started_d      = started_q;
        armed_d        = armed_q | vs_edge;
        frame_period_d = frame_period_q;
        lines_d        = lines_q;
        loss_d         = loss_q;

        // Every edge except the first after IDLE closes a complete frame.
        if (vs_edge && armed_q) begin
            frame_period_d = pctr_q;
            lines_d        = line_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_MEASURE;
            end

            ST_MEASURE: begin
                if (vs_edge) begin
                    if (!started_q) begin
                        started_d = 1'b1;
                    end else begin
                        ref_d     = pctr_q;
                        match_d   = 4'd0;
                        started_d = 1'b0;
                        state_d   = ST_VERIFY;
                    end
                end
            end

            ST_VERIFY: begin
                if (vs_edge) begin
                    if (in_tol) begin
                        match_d = match_inc[3:0];
                        if (match_inc >= LOCK_X) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        ref_d   = pctr_q;
                        match_d = 4'd0;
                    end
                end
            end

            ST_LOCKED: begin
                if (vs_edge && !in_tol) begin
                    // The offending edge already starts the next measurement.
                    state_d   = ST_MEASURE;
                    started_d = 1'b1;
                    loss_d    = (loss_q == LOSS_MAX) ? loss_q : loss_q + 8'd1;
                end else if (!vs_edge && timeout) begin
                    state_d   = ST_MEASURE;
                    started_d = 1'b0;
                    loss_d    = (loss_q == LOSS_MAX) ? loss_q : loss_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Idle (or a dropped enable) parks all counters at their reset values.
        if (hold_idle) begin
            pctr_d         = '0;
            line_d         = '0;
            ref_d          = '0;
            match_d        = '0;
            started_d      = 1'b0;
            armed_d        = 1'b0;
            frame_period_d = frame_period_q;
            lines_d        = lines_q;
            loss_d         = loss_q;
        end
        if (!enable) begin
            state_d = ST_IDLE;
        end

        sg_reset_n_d = (state_d == ST_LOCKED);
        locked_d     = (state_d == ST_LOCKED);
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge PCLK or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            sg_reset_n_q   <= 1'b0;
            locked_q       <= 1'b0;
            prev_vs_q      <= 1'b1;
            prev_hs_q      <= 1'b1;
            pctr_q         <= '0;
            line_q         <= '0;
            ref_q          <= '0;
            match_q        <= '0;
            started_q      <= 1'b0;
            armed_q        <= 1'b0;
            frame_period_q <= '0;
            lines_q        <= '0;
            loss_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q        <= state_d;
            sg_reset_n_q   <= sg_reset_n_d;
            locked_q       <= locked_d;
            prev_vs_q      <= VSYNC_ref;
            prev_hs_q      <= HSYNC_ref;
            pctr_q         <= pctr_d;
            line_q         <= line_d;
            ref_q          <= ref_d;
            match_q        <= match_d;
            started_q      <= started_d;
            armed_q        <= armed_d;
            frame_period_q <= frame_period_d;
            lines_q        <= lines_d;
            loss_q         <= loss_d;
        end
    end

    assign state           = state_q;
    assign sg_reset_n      = sg_reset_n_q;
    assign locked          = locked_q;
    assign frame_period    = frame_period_q;
    assign lines_per_frame = lines_q;
    assign loss_cnt        = loss_q;

endmodule

// File: tb/tb_sg_lock_ctrl.sv
// Bench for sg_lock_ctrl: directed scenarios plus randomized frames, every
// cycle compared against a timestamp-based reference model.

module tb_sg_lock_ctrl;

    localparam int CNT_W       = 11;
    localparam int TOL         = 4;
    localparam int LOCK_FRAMES = 3;
    localparam int PMAX        = (1 << CNT_W) - 1;

    logic             PCLK      = 1'b0;
    logic             reset     = 1'b0;
    logic             enable    = 1'b0;
    logic             HSYNC_ref = 1'b1;
    logic             VSYNC_ref = 1'b1;
    logic             sg_reset_n;
    logic             locked;
    logic [1:0]       state;
    logic [CNT_W-1:0] frame_period;
    logic [10:0]      lines_per_frame;
    logic [7:0]       loss_cnt;

    int total = 0;
    int bad   = 0;

    sg_lock_ctrl #(
        .CNT_W      (CNT_W),
        .TOL        (TOL),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .PCLK           (PCLK),
        .reset          (reset),
        .enable         (enable),
        .HSYNC_ref      (HSYNC_ref),
        .VSYNC_ref      (VSYNC_ref),
        .sg_reset_n     (sg_reset_n),
        .locked         (locked),
        .state          (state),
        .frame_period   (frame_period),
        .lines_per_frame(lines_per_frame),
        .loss_cnt       (loss_cnt)
    );

    always #5 PCLK = ~PCLK;

    // Reference model: periods come from cycle timestamps, not a counter.
    int m_state, m_now, m_base, m_lines, m_ref, m_match, m_fp, m_lpf, m_loss;
    bit m_prev_vs, m_prev_hs, m_started, m_armed;

    function automatic void model_clear();
        m_lines   = 0;
        m_ref     = 0;
        m_match   = 0;
        m_started = 0;
        m_armed   = 0;
    endfunction

    function automatic void model_init();
        model_clear();
        m_state   = 0;
        m_base    = m_now;
        m_fp      = 0;
        m_lpf     = 0;
        m_loss    = 0;
        m_prev_vs = 1;
        m_prev_hs = 1;
    endfunction

    function automatic void model_loss();
        if (m_loss < 255) m_loss++;
    endfunction

    function automatic void model_step(bit en, bit vs, bit hs);
        bit vse, hse;
        int p, dev;
        vse = m_prev_vs && !vs;
        hse = m_prev_hs && !hs;
        p   = m_now - m_base;
        if (p > PMAX) p = PMAX;
        dev = (p > m_ref) ? p - m_ref : m_ref - p;
        if (!en) begin
            m_state = 0;
            model_clear();
        end else if (m_state == 0) begin
            m_state = 1;
            m_base  = m_now + 1;
        end else begin
            if (vse && m_armed) begin
                m_fp  = p;
                m_lpf = m_lines;
            end
            case (m_state)
                1: if (vse) begin
                    if (!m_started) m_started = 1;
                    else begin
                        m_ref = p; m_match = 0; m_started = 0; m_state = 2;
                    end
                end
                2: if (vse) begin
                    if (dev <= TOL) begin
                        m_match++;
                        if (m_match >= LOCK_FRAMES) m_state = 3;
                    end else begin
                        m_ref = p; m_match = 0;
                    end
                end
                default: begin
                    if (vse && dev > TOL) begin
                        m_state = 1; m_started = 1; model_loss();
                    end else if (!vse && p > m_ref + TOL) begin
                        m_state = 1; m_started = 0; model_loss();
                    end
                end
            endcase
            if (vse) begin
                m_base  = m_now;
                m_lines = 0;
                m_armed = 1;
            end else if (hse && m_lines < 2047) begin
                m_lines++;
            end
        end
        m_prev_vs = vs;
        m_prev_hs = hs;
        m_now++;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, compare all outputs.
    task automatic tick(bit en, bit vs, bit hs);
        logic [63:0] exp_v, obs_v;
        enable    = en;
        VSYNC_ref = vs;
        HSYNC_ref = hs;
        model_step(en, vs, hs);
        @(posedge PCLK);
        #1;
        exp_v = 64'({2'(m_state), m_state == 3, m_state == 3,
                     CNT_W'(m_fp), 11'(m_lpf), 8'(m_loss)});
        obs_v = 64'({state, sg_reset_n, locked, frame_period, lines_per_frame, loss_cnt});
        check("cycle", obs_v, exp_v);
    endtask

    // One frame: VSYNC low for two cycles, optional HSYNC pulses every pitch cycles.
    task automatic frame(int period, int nlines = 0, int pitch = 3, int hs_off = 0);
        for (int c = 0; c < period; c++) begin
            bit vsv, hsv;
            vsv = (c < 2) ? 1'b0 : 1'b1;
            hsv = 1'b1;
            if (nlines > 0 && c >= hs_off && (c - hs_off) % pitch == 0 &&
                (c - hs_off) / pitch < nlines) hsv = 1'b0;
            tick(1'b1, vsv, hsv);
        end
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #3;
        reset     = 1'b1;
        enable    = 1'b0;
        VSYNC_ref = 1'b1;
        HSYNC_ref = 1'b1;
        #1;
        check("rst_state", 64'(state), 64'(0));
        check("rst_sg_reset_n", 64'(sg_reset_n), 64'(0));
        check("rst_locked", 64'(locked), 64'(0));
        check("rst_frame_period", 64'(frame_period), 64'(0));
        check("rst_lines", 64'(lines_per_frame), 64'(0));
        check("rst_loss", 64'(loss_cnt), 64'(0));
        model_init();
        @(posedge PCLK);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        m_now = 0;
        model_init();

        // Reset, then lock on a clean 1000-cycle reference.
        do_reset();
        tick(1'b1, 1'b1, 1'b1);
        check("enter_measure", 64'(state), 64'(1));
        frame(1000);
        check("first_edge_measure", 64'(state), 64'(1));
        frame(1000);
        check("second_edge_verify", 64'(state), 64'(2));
        frame(1000);
        frame(1000);
        check("fourth_edge_verify", 64'(state), 64'(2));
        frame(1000);
        check("fifth_edge_locked", 64'(state), 64'(3));
        check("fifth_edge_sg_reset_n", 64'(sg_reset_n), 64'(1));
        check("lock_frame_period", 64'(frame_period), 64'(1000));

        // 262 line edges per frame, the first coincident with VSYNC.
        frame(1000, 262, 3, 0);
        frame(1000, 262, 3, 0);
        check("lines_261", 64'(lines_per_frame), 64'(261));
        check("lines_still_locked", 64'(state), 64'(3));

        // VSYNC stops: loss exactly when the period reaches 1005.
        repeat (5) tick(1'b1, 1'b1, 1'b1);
        check("timeout_not_yet", 64'(state), 64'(3));
        tick(1'b1, 1'b1, 1'b1);
        check("timeout_state", 64'(state), 64'(1));
        check("timeout_sg_reset_n", 64'(sg_reset_n), 64'(0));
        check("timeout_loss", 64'(loss_cnt), 64'(1));
        repeat (5) frame(1000);
        check("relock_after_timeout", 64'(state), 64'(3));

        // Enable dropped while locked; relock takes the same edge count.
        tick(1'b0, 1'b1, 1'b1);
        check("disable_state", 64'(state), 64'(0));
        check("disable_sg_reset_n", 64'(sg_reset_n), 64'(0));
        check("disable_loss_kept", 64'(loss_cnt), 64'(1));
        tick(1'b1, 1'b1, 1'b1);
        repeat (4) frame(1000);
        check("reenable_verify", 64'(state), 64'(2));
        frame(1000);
        check("reenable_locked", 64'(state), 64'(3));

        // Jitter within tolerance locks.
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        frame(1000); frame(998); frame(1003); frame(998);
        check("jitter_verify", 64'(state), 64'(2));
        frame(1003);
        check("jitter_locked", 64'(state), 64'(3));

        // A 1005 period restarts the match count against ref=1005.
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        frame(1000); frame(998); frame(1005); frame(1005); frame(1003); frame(1007);
        check("mismatch_no_early_lock", 64'(state), 64'(2));
        frame(1000);
        check("mismatch_then_lock", 64'(state), 64'(3));
        check("mismatch_period", 64'(frame_period), 64'(1007));

        // Asynchronous reset in the middle of a frame.
        repeat (300) tick(1'b1, 1'b1, 1'b1);
        do_reset();

        // Randomized frames, enable drops and VSYNC dropouts.
        tick(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 150; i++) begin
            int r, per;
            r = $urandom_range(0, 99);
            if (r < 5) begin
                tick(1'b0, 1'b1, 1'b1);
                tick(1'b1, 1'b1, 1'b1);
            end else if (r < 10) begin
                repeat ($urandom_range(30, 80)) tick(1'b1, 1'b1, 1'b1);
            end else begin
                per = 40 + ((r < 80) ? $urandom_range(0, 4) : $urandom_range(5, 12));
                frame(per, $urandom_range(0, 20), 2, $urandom_range(0, 1));
            end
        end

        // 256 losses: the counter saturates at 255.
        do_reset();
        tick(1'b1, 1'b1, 1'b1);
        repeat (5) frame(20);
        check("short_locked", 64'(state), 64'(3));
        for (int i = 0; i < 256; i++) begin
            frame(30);
            repeat (4) frame(20);
            if (i == 0) check("first_edge_loss", 64'(loss_cnt), 64'(1));
            if (i == 254) check("loss_reaches_255", 64'(loss_cnt), 64'(255));
        end
        check("loss_saturated", 64'(loss_cnt), 64'(255));

        // No VSYNC long enough to saturate the period counter in MEASURE.
        do_reset();
        tick(1'b1, 1'b1, 1'b1);
        frame(20);
        repeat (2100) tick(1'b1, 1'b1, 1'b1);
        check("sat_stays_measure", 64'(state), 64'(1));
        tick(1'b1, 1'b0, 1'b1);
        check("sat_to_verify", 64'(state), 64'(2));
        check("sat_period_all_ones", 64'(frame_period), 64'(PMAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
